// File: rtl/alavanca2serial.sv
// alavanca2serial: packs two signed 16-bit lever values into a 6-byte
// checksummed frame and sends it as UART 8N1 on TX.
module alavanca2serial #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] al1Bits,
  input  logic [15:0] al2Bits,
  input  logic        enviar,
  output logic        TX,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [3:0] {OCIOSO = 4'd0, INICIO = 4'd1, DADOS = 4'd2, PARADA = 4'd3, FIM = 4'd4} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n, byte_idx, byte_n;
  logic [5:0][7:0] frm;
  logic tick;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n = tick ? '0 : cnt + CW'(1);
    bit_n = bit_idx;
    byte_n = byte_idx;
    case (state)
      OCIOSO: begin
        cnt_n = '0;
        if (enviar) begin
          state_n = INICIO;
          byte_n = 3'd0;
        end
      end
      INICIO: if (tick) begin
        state_n = DADOS;
        bit_n = 3'd0;
      end
      DADOS: if (tick) begin
        bit_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = PARADA;
      end
      PARADA: if (tick) begin
        if (byte_idx < 3'd5) begin
          byte_n = byte_idx + 3'd1;
          state_n = INICIO;
        end else state_n = FIM;
      end
      FIM: begin
        cnt_n = '0;
        state_n = OCIOSO;
      end
      default: state_n = OCIOSO;
    endcase
  end
  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= OCIOSO;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      frm <= '0;
      TX <= 1'b1;
      ocupado <= 1'b0;
      pronto <= 1'b0;
      db_estado <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      byte_idx <= byte_n;
      if (state == OCIOSO && enviar)
        frm <= {al1Bits[15:8] ^ al1Bits[7:0] ^ al2Bits[15:8] ^ al2Bits[7:0],
                al2Bits[7:0], al2Bits[15:8], al1Bits[7:0], al1Bits[15:8], SYNC_BYTE};
      TX <= state == INICIO ? 1'b0 : state == DADOS ? frm[byte_idx][bit_idx] : 1'b1;
      ocupado <= state != OCIOSO;
      pronto <= state == FIM;
      db_estado <= state;
    end
  end
endmodule

// File: tb/tb_alavanca2serial.sv
// tb_alavanca2serial: scoreboard bench; a line monitor decodes TX and pops
// expected bytes pushed when each request is driven.
module tb_alavanca2serial;
  localparam int C = 4;
  localparam int CL = 434;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] a1 = '0, a2 = '0, b1 = '0, b2 = '0;
  logic en = 1'b0, lb_en = 1'b0;
  logic tx, ocup, pr, lb_tx, lb_ocup, lb_pr;
  logic [3:0] st, lb_st;
  int checks = 0, errors = 0, cyc = 0, acc = 0, t = 0, lb_got = 0;
  logic [7:0] sb[$];
  logic [31:0] lb_sb[$];

  alavanca2serial #(.CLKS_PER_BIT(C)) dut (
    .clock(clk), .reset(rst), .al1Bits(a1), .al2Bits(a2), .enviar(en),
    .TX(tx), .ocupado(ocup), .pronto(pr), .db_estado(st));
  alavanca2serial dut_lb (
    .clock(clk), .reset(rst), .al1Bits(b1), .al2Bits(b2), .enviar(lb_en),
    .TX(lb_tx), .ocupado(lb_ocup), .pronto(lb_pr), .db_estado(lb_st));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task push_frame(input logic [15:0] x, input logic [15:0] y);
    sb.push_back(8'hA5);
    sb.push_back(x[15:8]);
    sb.push_back(x[7:0]);
    sb.push_back(y[15:8]);
    sb.push_back(y[7:0]);
    sb.push_back(x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0]);
  endtask

  task send(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a1 = x; a2 = y; en = 1'b1;
    push_frame(x, y);
    @(negedge clk);
    acc = cyc;
    en = 1'b0;
  endtask

  task wait_cyc(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
  endtask

  task frame_timing();
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pr) begin t = cyc - acc; break; end
    end
    check("pronto_time", t, 241);
    check("fim_state", st, 4);
    t = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ocup) begin t = cyc - acc; break; end
    end
    check("ocupado_fall", t, 242);
    check("pronto_width", pr, 0);
  endtask

  task lb_send(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    b1 = x; b2 = y; lb_en = 1'b1;
    lb_sb.push_back({x, y});
    @(negedge clk);
    lb_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 27000 && lb_ocup; i++) @(negedge clk);
    check("lb_done", lb_ocup, 0);
  endtask

  logic [9:0] v;
  logic ok, ab;
  always begin
    @(negedge clk);
    if (!rst && !tx) begin
      ok = 1'b1; ab = 1'b0;
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < C; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst) ab = 1'b1;
          if (c == 0) v[b] = tx;
          else if (tx !== v[b]) ok = 1'b0;
        end
      if (ab) sb.delete();
      else if (sb.size() == 0) check("extra_byte", sb.size(), 1);
      else begin
        check("byte", v, {1'b1, sb.pop_front(), 1'b0});
        check("bit_width", ok, 1);
      end
    end
  end

  logic [7:0] d;
  logic [7:0] fr[6];
  int n = 0;
  logic [31:0] e;
  always begin
    @(negedge clk);
    if (!rst && !lb_tx) begin
      repeat (CL / 2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CL) @(negedge clk);
        d[b] = lb_tx;
      end
      repeat (CL) @(negedge clk);
      if (lb_tx && (n != 0 || d == 8'hA5)) begin
        fr[n] = d;
        n++;
        if (n == 6) begin
          n = 0;
          if (lb_sb.size() == 0) check("lb_extra", lb_sb.size(), 1);
          else begin
            e = lb_sb.pop_front();
            check("lb_pair", {fr[1], fr[2], fr[3], fr[4]}, e);
            check("lb_chk", fr[5], e[31:24] ^ e[23:16] ^ e[15:8] ^ e[7:0]);
            lb_got++;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("reset_idle", {tx, ocup, pr, st}, 7'b1000000);
    end
    send(16'h1234, 16'hFFFE);
    check("tx_before_start", tx, 1);
    @(negedge clk);
    check("start_bit", tx, 0);
    check("busy", ocup, 1);
    repeat (40) @(negedge clk);
    a1 = 16'h0000; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (30) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    frame_timing();
    repeat (100) @(negedge clk);
    check("no_second_frame", ocup, 0);
    check("sb_empty_single", sb.size(), 0);
    @(negedge clk);
    a1 = 16'h0102; a2 = 16'h8000; en = 1'b1;
    push_frame(a1, a2);
    @(negedge clk);
    acc = cyc;
    a1 = 16'hBEEF; a2 = 16'h00FF;
    push_frame(a1, a2);
    wait_cyc(acc + 242);
    check("b2b_gap", ocup, 0);
    a1 = 16'h7F80; a2 = 16'hFFFF;
    push_frame(a1, a2);
    t = -1;
    for (int i = 0; i < 5; i++) begin
      if (!tx) begin t = cyc - acc; break; end
      @(negedge clk);
    end
    check("b2b_start", t, 243);
    wait_cyc(acc + 484);
    check("b2b_gap2", ocup, 0);
    en = 1'b0;
    acc = acc + 484;
    frame_timing();
    repeat (50) @(negedge clk);
    check("sb_empty_b2b", sb.size(), 0);
    send(16'hCAFE, 16'h0055);
    wait_cyc(acc + 86);
    check("mid_byte2_busy", ocup, 1);
    rst = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_ocup", ocup, 0);
    check("abort_state", st, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_flushed", sb.size(), 0);
    send(16'h00A5, 16'h5A00);
    frame_timing();
    repeat (20) @(negedge clk);
    check("sb_empty_after_abort", sb.size(), 0);
    lb_send(16'h8000, 16'h7FFF);
    lb_send(16'h0000, 16'hFFFF);
    repeat (10) @(negedge clk);
    check("lb_frames", lb_got, 2);
    check("lb_sb_empty", lb_sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alavanca2serial.md
# alavanca2serial

Serial encoder for the lever pair: accepts two signed 16-bit lever values, packs them into a 6-byte checksummed frame and shifts it out as UART 8N1 on `TX`. It is the transmit end of the lever link. `TX` connects directly to the `RX` input of `serial2alavanca`, which must decode `al1Bits`/`al2Bits` unchanged. It serves as the stimulus source in the board loopback test and in the PC-less demo build.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200 baud); legal range ≥ 2.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

**Ports**
- `clock`  in  1  system clock, single domain.
- `reset`  in  1  asynchronous, active-high reset.
- `al1Bits`  in  16  lever 1 value, signed two's complement.
- `al2Bits`  in  16  lever 2 value, signed two's complement.
- `enviar`  in  1  request to send one frame; level-sampled.
- `TX`  out  1  UART line; idle high.
- `ocupado`  out  1  high while a frame is in flight.
- `pronto`  out  1  one-cycle pulse when the frame's last stop bit completes.
- `db_estado`  out  4  current FSM state code, for debug.

## Operation

**Frame format**
- Byte order: `SYNC_BYTE`, al1[15:8], al1[7:0], al2[15:8], al2[7:0], CHK.
- CHK = al1[15:8] ^ al1[7:0] ^ al2[15:8] ^ al2[7:0].

**Byte encoding**
- Each byte is sent as 8N1: start bit 0, data bits LSB first, one stop bit 1.
- Bytes are sent back-to-back with no idle gap.

**Acceptance**
- A request is accepted in any cycle where `enviar`=1 and `ocupado`=0.
- On acceptance, `al1Bits`/`al2Bits` are latched and CHK is computed. Input changes after that cycle do not affect the frame.
- `enviar` is ignored while `ocupado`=1; it is not queued.

**FSM states (`db_estado` codes)**
- OCIOSO (0): idle.
  - `TX`=1, `ocupado`=0.
  - On acceptance: load byte index 0, go to INICIO.
- INICIO (1): drive start bit 0 for `CLKS_PER_BIT` cycles, then go to DADOS with bit index 0.
- DADOS (2): drive byte[bit] for `CLKS_PER_BIT` cycles per bit.
  - After bit 7, go to PARADA.
- PARADA (3): drive 1 for `CLKS_PER_BIT` cycles.
  - If byte index < 5: increment the index and go to INICIO.
  - Otherwise go to FIM.
- FIM (4): `TX`=1 and `pronto`=1 for exactly one cycle, then go to OCIOSO.

**Counters**
- Baud counter: 0..`CLKS_PER_BIT`-1, sized by `$clog2`; resets to 0 on every state or bit transition.
- Bit index: 3 bits.
- Byte index: 3 bits, range 0..5.

**Registered outputs**
- `TX`, `ocupado`, `pronto` and `db_estado` are driven from registers. There is no combinational path from inputs to outputs.

**Reset**
- Values during reset: `TX`=1, `ocupado`=0, `pronto`=0, `db_estado`=0, all counters 0.
- Reset asserted mid-frame aborts the frame immediately. `TX` returns high asynchronously. No partial-frame recovery is attempted; the receiver resynchronises on the next `SYNC_BYTE`.

## Timing

Let acceptance occur in the cycle ending at edge N, and C = `CLKS_PER_BIT`.

- `ocupado`=1 and `TX`=0 from edge N+1.
- Byte k (k = 0..5) start bit occupies edges N+1+10kC through N+10kC+C.
- Bit b of byte k appears at edge N+1+10kC+(b+1)C.
- The last stop bit ends at N+60C.
- At edge N+1+60C: `pronto`=1, `ocupado`=1, state FIM.
- At edge N+2+60C: `ocupado`=0. A request held high then is accepted at that edge, so the minimum frame period is 60C+2 cycles.
- Latency from acceptance to the first `TX` falling edge is 1 cycle.
- Negative values need no special handling: the 16-bit pattern is sent as-is (e.g. -1 → FF FF).

## Test plan

- **Reset values:** assert `reset` for 3 cycles, then release with `enviar`=0 → `TX`=1, `ocupado`=0, `pronto`=0, `db_estado`=0 for 100 cycles.
- **Single frame:** C=4, al1=16'h1234, al2=16'hFFFE, one-cycle `enviar` → bytes A5 12 34 FF FE, CHK=12^34^FF^FE=0x27, LSB first.
  - Each bit lasts exactly 4 cycles.
  - `pronto` pulses at N+1+240.
  - `ocupado` falls at N+242.
- **Input latching / busy ignore:** change al1 to 16'h0000 and pulse `enviar` twice mid-frame → the frame still carries 12 34; no second frame follows.
- **Back-to-back:** hold `enviar`=1 continuously → second start bit at exactly N+242+1; 3 consecutive frames decode correctly.
- **Loopback:** connect `TX` to `serial2alavanca.RX` with the default C; send (-32768, 32767) then (0, -1) → the receiver's `al1Bits`/`al2Bits` match both pairs.
- **Reset mid-frame:** assert `reset` during byte 2 → `TX`=1 in the same cycle. After release, a new request yields a complete, correct frame.
